// File: rtl/xor_end_perm_pipe_if.sv
// ---------------------------------------------------------------------------
// ascon_pack / xor_end_perm_pipe_if
//
// ascon_pack  : the 5 x 64-bit ASCON state. x0 is the most significant word,
//               so casting a type_state to logic [319:0] gives {x0,..,x4}
//               with x4[0] as bit 0.
// xor_end_perm_pipe_if : groups every data/handshake signal of the
//               end-of-permutation XOR stage.
//   in_valid_i / in_ready_o   input transaction handshake
//   mode_i, key_i, registerS_i input payload (00 PASS, 01 DOMAIN, 10 KEY, 11 TAG)
//   out_valid_o / out_ready_i result handshake, registerS_o result state
//   tag_valid_o / tag_ready_i tag beat handshake, tag_data_o beat, tag_last_o
//   modport slave  : the stage itself
//   modport master : upstream producer plus downstream consumers
// ---------------------------------------------------------------------------
package ascon_pack;
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;
endpackage

interface xor_end_perm_pipe_if #(
  parameter int KEY_W = 128,
  parameter int TAG_W = 64
);
  import ascon_pack::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       mode_i;
  logic [KEY_W-1:0] key_i;
  type_state        registerS_i;
  logic             out_valid_o;
  logic             out_ready_i;
  type_state        registerS_o;
  logic             tag_valid_o;
  logic             tag_ready_i;
  logic [TAG_W-1:0] tag_data_o;
  logic             tag_last_o;

  modport slave (
    input  in_valid_i, mode_i, key_i, registerS_i, out_ready_i, tag_ready_i,
    output in_ready_o, out_valid_o, registerS_o, tag_valid_o, tag_data_o, tag_last_o
  );

  modport master (
    output in_valid_i, mode_i, key_i, registerS_i, out_ready_i, tag_ready_i,
    input  in_ready_o, out_valid_o, registerS_o, tag_valid_o, tag_data_o, tag_last_o
  );
endinterface

// File: rtl/xor_end_perm_pipe.sv
// ---------------------------------------------------------------------------
// xor_end_perm_pipe
//
// Registered end-of-permutation XOR stage of the ASCON datapath. Each accepted
// transaction is turned into one of PASS / DOMAIN / KEY / TAG results and held
// in a one-entry valid/ready output stage. TAG transactions additionally load
// the 128-bit tag (pre-XOR state low half XOR key low half) into a shift
// register that is streamed out MSB-first in TAG_W-bit beats.
//
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-high reset
//   bus      xor_end_perm_pipe_if.slave (all handshake and payload signals)
// Parameters:
//   KEY_W    128 or 160; the key is XORed into bits [KEY_W-1:0] of the state
//   TAG_W    32, 64 or 128; tag beat width, NB = 128/TAG_W beats
// The interface instance must use the same KEY_W/TAG_W as this module.
// ---------------------------------------------------------------------------
module xor_end_perm_pipe
  import ascon_pack::*;
#(
  parameter int KEY_W = 128,
  parameter int TAG_W = 64
) (
  input logic                clock_i,
  input logic                reset_i,
  xor_end_perm_pipe_if.slave bus
);

  localparam int NB = 128 / TAG_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_DOMAIN = 2'b01;
  localparam logic [1:0] MODE_KEY    = 2'b10;
  localparam logic [1:0] MODE_TAG    = 2'b11;

  if (!(KEY_W == 128 || KEY_W == 160)) begin : g_bad_key_w
    $error("xor_end_perm_pipe: KEY_W must be 128 or 160");
  end
  if (!(TAG_W == 32 || TAG_W == 64 || TAG_W == 128)) begin : g_bad_tag_w
    $error("xor_end_perm_pipe: TAG_W must be 32, 64 or 128");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } tag_st_e;

  logic [319:0] c_s;
  logic [319:0] key_ext_s;
  logic [319:0] res_s;
  logic [127:0] tag_s;
  logic         tag_busy_s;
  logic         in_ready_s;
  logic         accept_s;

  logic         out_valid_q, out_valid_d;
  logic [319:0] res_q, res_d;
  tag_st_e      st_q, st_d;
  logic [127:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign c_s       = bus.registerS_i;
  // For KEY_W=160 the key reaches into x2[31:0]; upper bits are untouched.
  assign key_ext_s = {{(320 - KEY_W){1'b0}}, bus.key_i};
  // The tag is taken from the state before the key XOR.
  assign tag_s     = c_s[127:0] ^ bus.key_i[127:0];

  assign tag_busy_s = (st_q == ST_STREAM);
  // No input of any mode while a tag is streaming, so a new tag never
  // overwrites one that is only partly delivered.
  assign in_ready_s = (!out_valid_q || bus.out_ready_i) && !tag_busy_s;
  assign accept_s   = bus.in_valid_i && in_ready_s;

  // Post-permutation operation select.
  always_comb begin
    res_s = c_s;
    case (bus.mode_i)
      MODE_PASS:   res_s = c_s;
      MODE_DOMAIN: res_s = c_s ^ 320'd1;
      MODE_KEY:    res_s = c_s ^ key_ext_s;
      MODE_TAG:    res_s = c_s ^ key_ext_s;
      default:     res_s = c_s;
    endcase
  end

  // One-entry output stage; accept-and-drain in one cycle keeps valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      res_d       = res_s;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Tag engine next-state: load on TAG acceptance, shift one beat per handshake.
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE: begin
        if (accept_s && (bus.mode_i == MODE_TAG)) begin
          st_d  = ST_STREAM;
          sh_d  = tag_s;
          cnt_d = '0;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (bus.tag_ready_i) begin
          sh_d = sh_q << TAG_W;
          if (cnt_q == LAST_CNT) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          st_d = ST_STREAM;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        sh_d  = '0;
        cnt_d = '0;
      end
    endcase
  end

  // State registers; reset drops any partially streamed tag.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      st_q        <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      st_q        <= st_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_q;
  assign bus.registerS_o = res_q;
  assign bus.tag_valid_o = tag_busy_s;
  assign bus.tag_data_o  = sh_q[127 -: TAG_W];
  assign bus.tag_last_o  = tag_busy_s && (cnt_q == LAST_CNT);

endmodule
